// File: rtl/wb_merge.sv
// Writeback merge: in-order pipeline results own the register write port, long-latency
// results queue in a small FIFO and drain into idle slots. Optional: `WB_MERGE_STATS_EN.
module wb_merge #(
   parameter int DEPTH = 4,
   parameter int AW    = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        pipe_we,
   input  logic [3:0]  pipe_addr,
   input  logic [31:0] pipe_data,
   input  logic        ml_valid,
   input  logic [3:0]  ml_addr,
   input  logic [31:0] ml_data,
   output logic        ml_ready,
   input  logic        issue_valid,
   input  logic [3:0]  issue_addr,
   input  logic [3:0]  addr_a,
   input  logic [3:0]  addr_b,
   output logic        busy_a,
   output logic        busy_b,
   output logic        busy_d,
   output logic [3:0]  addr_d,
   output logic [31:0] data_d,
   output logic        we,
   output logic [31:0] ml_stall_cnt
);

   // Handshake: a long-latency result transfers on a clock edge where ml_valid && ml_ready;
   // ml_ready depends only on the registered count, so a pop never frees a slot the same cycle.
   localparam logic [AW:0]   L_FULL    = (AW+1)'(DEPTH);
   localparam logic [AW:0]   L_CNT_ONE = (AW+1)'(1);
   localparam logic [AW-1:0] L_PTR_ONE = AW'(1);

   logic [3:0]    r_fifo_addr [DEPTH];
   logic [31:0]   r_fifo_data [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_count;
   logic [15:0]   r_mask;
   logic          r_we;
   logic [3:0]    r_addr_d;
   logic [31:0]   r_data_d;

   logic          w_push;
   logic          w_pop;
   logic          w_pipe_sel;
   logic          w_empty;
   logic [3:0]    w_head_addr;
   logic [31:0]   w_head_data;
   logic [15:0]   w_mask_nxt;

   assign w_empty     = (r_count == '0);
   assign ml_ready    = (r_count != L_FULL);
   assign w_push      = ml_valid && ml_ready;
   assign w_pipe_sel  = pipe_we && (pipe_addr != 4'd0);
   assign w_pop       = !w_pipe_sel && !w_empty;
   assign w_head_addr = r_fifo_addr[r_rd_ptr];
   assign w_head_data = r_fifo_data[r_rd_ptr];

   // Storage has no reset; validity is carried entirely by the pointers and count.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_fifo_addr[r_wr_ptr] <= ml_addr;
         r_fifo_data[r_wr_ptr] <= ml_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + L_PTR_ONE;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + L_PTR_ONE;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + L_CNT_ONE;
            2'b01:   r_count <= r_count - L_CNT_ONE;
            default: r_count <= r_count;
         endcase
      end
   end

   // Clear is applied before set so an issue landing on the popping register keeps it pending.
   always_comb begin
      w_mask_nxt = r_mask;
      if (w_pop)       w_mask_nxt[w_head_addr] = 1'b0;
      if (issue_valid) w_mask_nxt[issue_addr]  = 1'b1;
      w_mask_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (!reset) r_mask <= '0;
      else        r_mask <= w_mask_nxt;
   end

   assign busy_a = r_mask[addr_a];
   assign busy_b = r_mask[addr_b];
   assign busy_d = issue_valid && r_mask[issue_addr];

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_we     <= 1'b0;
         r_addr_d <= 4'd0;
         r_data_d <= 32'd0;
      end else if (w_pipe_sel) begin
         r_we     <= 1'b1;
         r_addr_d <= pipe_addr;
         r_data_d <= pipe_data;
      end else if (w_pop) begin
         r_we     <= (w_head_addr != 4'd0);
         r_addr_d <= w_head_addr;
         r_data_d <= w_head_data;
      end else begin
         r_we     <= 1'b0;
      end
   end

   assign we     = r_we;
   assign addr_d = r_addr_d;
   assign data_d = r_data_d;

`ifdef WB_MERGE_STATS_EN
   logic [31:0] r_stall_cnt;

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_stall_cnt <= 32'd0;
      end else if (ml_valid && !ml_ready && (r_stall_cnt != 32'hFFFF_FFFF)) begin
         r_stall_cnt <= r_stall_cnt + 32'd1;
      end
   end

   assign ml_stall_cnt = r_stall_cnt;

   // Flags upstream hazard-contract breaches; never synthesised into checking hardware.
   always_ff @(posedge clk) begin
      if (reset) begin
         assert (!(w_pipe_sel && r_mask[pipe_addr]))
            else $error("wb_merge: pipeline write to pending register %0d", pipe_addr);
         assert (!busy_d)
            else $error("wb_merge: issue to pending register %0d", issue_addr);
      end
   end
`else
   assign ml_stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_wb_merge.sv
// Randomised and directed bench for wb_merge: a queue-based reference model predicts
// register writes into a scoreboard that a negedge monitor drains.
module tb_wb_merge;

   localparam int DEPTH = 4;

   typedef struct {
      logic [3:0]  a;
      logic [31:0] d;
   } ent_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        pipe_we;
   logic [3:0]  pipe_addr;
   logic [31:0] pipe_data;
   logic        ml_valid;
   logic [3:0]  ml_addr;
   logic [31:0] ml_data;
   logic        ml_ready;
   logic        issue_valid;
   logic [3:0]  issue_addr;
   logic [3:0]  addr_a;
   logic [3:0]  addr_b;
   logic        busy_a;
   logic        busy_b;
   logic        busy_d;
   logic [3:0]  addr_d;
   logic [31:0] data_d;
   logic        we;
   logic [31:0] ml_stall_cnt;

   wb_merge #(.DEPTH(DEPTH), .AW(2)) dut (
      .clk(clk), .reset(reset),
      .pipe_we(pipe_we), .pipe_addr(pipe_addr), .pipe_data(pipe_data),
      .ml_valid(ml_valid), .ml_addr(ml_addr), .ml_data(ml_data), .ml_ready(ml_ready),
      .issue_valid(issue_valid), .issue_addr(issue_addr),
      .addr_a(addr_a), .addr_b(addr_b),
      .busy_a(busy_a), .busy_b(busy_b), .busy_d(busy_d),
      .addr_d(addr_d), .data_d(data_d), .we(we), .ml_stall_cnt(ml_stall_cnt)
   );

   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_pass   = 0;
   logic [35:0] exp_q[$];
   ent_t        ml_q[$];
   bit          m_mask[16];
   logic [31:0] m_stall;
   bit          m_pushed;
   logic [3:0]  outst[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      else n_pass++;
   endtask

   always @(negedge clk) begin
      if (we === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("unexpected_we", {28'd0, addr_d}, 32'hFFFF_FFFF);
         end else begin
            logic [35:0] e;
            e = exp_q.pop_front();
            check("wr_addr", {28'd0, addr_d}, {28'd0, e[35:32]});
            check("wr_data", data_d, e[31:0]);
         end
      end
   end

   task automatic idle_inputs();
      pipe_we = 1'b0; pipe_addr = 4'd0; pipe_data = 32'd0;
      ml_valid = 1'b0; ml_addr = 4'd0; ml_data = 32'd0;
      issue_valid = 1'b0; issue_addr = 4'd0;
   endtask

   // One clock: check combinational outputs against the model, advance the model, clock.
   task automatic cycle();
      bit rdy;
      #1;
      rdy = (ml_q.size() < DEPTH);
      check("ml_ready", {31'd0, ml_ready}, {31'd0, rdy});
      check("busy_a", {31'd0, busy_a}, {31'd0, m_mask[addr_a]});
      check("busy_b", {31'd0, busy_b}, {31'd0, m_mask[addr_b]});
      check("busy_d", {31'd0, busy_d}, {31'd0, issue_valid && m_mask[issue_addr]});
      check("stall_cnt", ml_stall_cnt, m_stall);
      m_pushed = 1'b0;
      if (!reset) begin
         ml_q.delete();
         foreach (m_mask[i]) m_mask[i] = 1'b0;
         m_stall = 32'd0;
      end else begin
`ifdef WB_MERGE_STATS_EN
         if (ml_valid && !rdy && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 32'd1;
`endif
         if (pipe_we && pipe_addr != 4'd0) begin
            exp_q.push_back({pipe_addr, pipe_data});
         end else if (ml_q.size() > 0) begin
            ent_t e;
            e = ml_q.pop_front();
            if (e.a != 4'd0) exp_q.push_back({e.a, e.d});
            m_mask[e.a] = 1'b0;
         end
         if (ml_valid && rdy) begin
            ml_q.push_back('{a: ml_addr, d: ml_data});
            m_pushed = 1'b1;
         end
         if (issue_valid && issue_addr != 4'd0) m_mask[issue_addr] = 1'b1;
      end
      @(posedge clk);
      #1;
   endtask

   function automatic logic [3:0] pick_free();
      logic [3:0] s;
      s = 4'($urandom_range(15, 1));
      for (int k = 0; k < 16; k++) begin
         if (s != 4'd0 && !m_mask[s]) return s;
         s = s + 4'd1;
      end
      return 4'd0;
   endfunction

   initial begin
      logic [31:0] dv;
      int          idx;
      idle_inputs();
      addr_a = 4'd0; addr_b = 4'd0;
      m_stall = 32'd0;
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;

      // Reset then idle
      repeat (5) cycle();
      check("rst_we", {31'd0, we}, 32'd0);
      check("rst_addr_d", {28'd0, addr_d}, 32'd0);
      check("rst_data_d", data_d, 32'd0);

      // Pipe-only path
      pipe_we = 1'b1; pipe_addr = 4'd3; pipe_data = 32'h1234;
      cycle();
      check("pipe_we", {31'd0, we}, 32'd1);
      check("pipe_addr", {28'd0, addr_d}, 32'd3);
      check("pipe_data", data_d, 32'h1234);
      idle_inputs();
      cycle();
      check("pipe_we_drop", {31'd0, we}, 32'd0);

      // Issue then drain
      issue_valid = 1'b1; issue_addr = 4'd5;
      cycle();
      idle_inputs();
      addr_a = 4'd5;
      #1 check("busy_a_set", {31'd0, busy_a}, 32'd1);
      repeat (2) cycle();
      ml_valid = 1'b1; ml_addr = 4'd5; ml_data = 32'hDEAD_BEEF;
      cycle();
      idle_inputs();
      check("busy_a_queued", {31'd0, busy_a}, 32'd1);
      cycle();
      check("drain_we", {31'd0, we}, 32'd1);
      check("drain_addr", {28'd0, addr_d}, 32'd5);
      check("drain_data", data_d, 32'hDEAD_BEEF);
      check("busy_a_clear", {31'd0, busy_a}, 32'd0);

      // Priority and fill
      pipe_we = 1'b1; pipe_addr = 4'd1;
      for (int i = 0; i < 4; i++) begin
         pipe_data = $urandom;
         ml_valid = 1'b1; ml_addr = 4'(6 + i); ml_data = 32'h100 + i;
         cycle();
      end
      pipe_data = $urandom;
      ml_addr = 4'd10; ml_data = 32'h555;
      #1 check("full_not_ready", {31'd0, ml_ready}, 32'd0);
      cycle();
`ifdef WB_MERGE_STATS_EN
      check("stall_one", ml_stall_cnt, 32'd1);
`else
      check("stall_zero", ml_stall_cnt, 32'd0);
`endif
      idle_inputs();
      for (int i = 0; i < 4; i++) begin
         cycle();
         check("fill_order", {28'd0, addr_d}, 32'(6 + i));
      end
      cycle();

      // r0 handling
      ml_valid = 1'b1; ml_addr = 4'd0; ml_data = 32'hAAAA;
      cycle();
      idle_inputs();
      cycle();
      check("r0_drain_we", {31'd0, we}, 32'd0);
      check("r0_drain_addr", {28'd0, addr_d}, 32'd0);
      check("r0_drain_data", data_d, 32'hAAAA);
      pipe_we = 1'b1; pipe_addr = 4'd2; pipe_data = 32'h22;
      ml_valid = 1'b1; ml_addr = 4'd7; ml_data = 32'h7777;
      cycle();
      ml_valid = 1'b0; pipe_addr = 4'd0;
      cycle();
      check("pipe_r0_drain", {28'd0, addr_d}, 32'd7);
      idle_inputs();
      cycle();

      // Reset mid-operation
      for (int i = 0; i < 3; i++) begin
         issue_valid = 1'b1; issue_addr = 4'(10 + i);
         cycle();
      end
      idle_inputs();
      pipe_we = 1'b1; pipe_addr = 4'd1;
      for (int i = 0; i < 3; i++) begin
         pipe_data = $urandom;
         ml_valid = 1'b1; ml_addr = 4'(10 + i); ml_data = $urandom;
         cycle();
      end
      idle_inputs();
      reset = 1'b0;
      issue_valid = 1'b1; issue_addr = 4'd10;
      #1 check("busy_d_pending", {31'd0, busy_d}, 32'd1);
      cycle();
      reset = 1'b1;
      idle_inputs();
      for (int i = 0; i < 4; i++) begin
         cycle();
         check("post_rst_we", {31'd0, we}, 32'd0);
      end
      for (int i = 0; i < 16; i++) begin
         addr_a = 4'(i);
         #1 check("post_rst_mask", {31'd0, busy_a}, 32'd0);
      end

      // Randomised traffic under the hazard contract
      for (int n = 0; n < 1500; n++) begin
         idle_inputs();
         addr_a = 4'($urandom_range(15, 0));
         addr_b = 4'($urandom_range(15, 0));
         reset = ($urandom_range(299, 0) == 0) ? 1'b0 : 1'b1;
         if ($urandom_range(3, 0) == 0) begin
            issue_addr = pick_free();
            issue_valid = (issue_addr != 4'd0);
         end
         idx = -1;
         if (outst.size() > 0 && $urandom_range(9, 0) < 4) begin
            idx = $urandom_range(outst.size() - 1, 0);
            ml_valid = 1'b1; ml_addr = outst[idx]; ml_data = $urandom;
         end else if ($urandom_range(19, 0) == 0) begin
            ml_valid = 1'b1; ml_addr = 4'd0; ml_data = $urandom;
         end
         if ($urandom_range(1, 0) == 1) begin
            pipe_we = 1'b1;
            pipe_addr = 4'($urandom_range(15, 0));
            if (m_mask[pipe_addr] || pipe_addr == issue_addr) pipe_addr = 4'd0;
            dv = $urandom;
            pipe_data = dv;
         end
         cycle();
         if (!reset) outst.delete();
         else begin
            if (m_pushed && idx >= 0) outst.delete(idx);
            if (issue_valid) outst.push_back(issue_addr);
         end
      end
      reset = 1'b1;
      idle_inputs();
      repeat (10) cycle();
      check("scoreboard_empty", exp_q.size(), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/wb_merge.md
Name: wb_merge

Overview:
- Writeback-stage merge unit that owns the single register-bank write port (`addr_d`, `data_d`, `we`).
- Merges two result sources:
  - in-order pipeline results (ALU, single-cycle paths), which always take priority;
  - results from long-latency units (divider, memory loads), which are buffered in a small FIFO and drained into free write-port slots.
- Keeps a per-register pending scoreboard so the REG stage can hold on RAW/WAW hazards against outstanding long-latency results.

Parameters:
- `DEPTH`, 4, number of long-latency result FIFO entries (power of two, 2..16).
- `AW`, 2, FIFO pointer width; must equal log2(`DEPTH`).

Ports:
- `clk`  in  1  system clock
- `reset`  in  1  synchronous reset, active-low (0 = reset), sampled on rising edge of `clk`
- `pipe_we`  in  1  in-order pipeline result valid
- `pipe_addr`  in  4  destination register of pipeline result
- `pipe_data`  in  32  pipeline result value
- `ml_valid`  in  1  long-latency result valid
- `ml_addr`  in  4  long-latency destination register
- `ml_data`  in  32  long-latency result value
- `ml_ready`  out  1  FIFO can accept a long-latency result this cycle
- `issue_valid`  in  1  REG stage issues a long-latency op this cycle
- `issue_addr`  in  4  destination register of issued op
- `addr_a`  in  4  REG-stage read address A
- `addr_b`  in  4  REG-stage read address B
- `busy_a`  out  1  `addr_a` has a pending long-latency write (combinational)
- `busy_b`  out  1  `addr_b` has a pending long-latency write (combinational)
- `busy_d`  out  1  `issue_addr` has a pending write; WAW hazard (combinational)
- `addr_d`  out  4  register bank write address
- `data_d`  out  32  register bank write data
- `we`  out  1  register bank write enable
- `ml_stall_cnt`  out  32  count of cycles with `ml_valid` && !`ml_ready` (see Optional Feature)

Behaviour:
- Reset (`reset`==0 at a clock edge): FIFO emptied (pointers 0, count 0), pending mask 0, `we`=0, `addr_d`=0, `data_d`=0, `ml_stall_cnt`=0.
  - In-flight FIFO entries and pending bits are discarded; no write is issued in the reset cycle.
- FIFO push:
  - `ml_ready` = (count != `DEPTH`), combinational from registered count.
  - Push occurs when `ml_valid` && `ml_ready`.
  - Entries with `ml_addr`==0 are pushed normally; their drain produces `we`=0.
- Write-port selection, computed each cycle and registered (latency 1 cycle):
  - `pipe_we`==1 && `pipe_addr`!=0: output pipeline result; FIFO does not drain.
  - Otherwise, if FIFO non-empty: pop head; output `we`=(head addr!=0), `addr_d`=head addr, `data_d`=head data.
  - Otherwise: `we`=0; `addr_d`/`data_d` hold their previous values.
- Pipeline write to r0: treated as no write; the FIFO may drain that cycle.
- Simultaneous push and pop: both occur; count unchanged. When full, a pop does not make `ml_ready` high in the same cycle (registered count).
- Pointer wrap: modulo `DEPTH`.
- Pending mask (16 bits, bit 0 forced to 0):
  - Set bit `issue_addr` on `issue_valid`.
  - Clear bit of head addr on pop.
  - Set and clear of the same bit in the same cycle: set wins.
- Busy outputs:
  - `busy_a` = mask[`addr_a`], `busy_b` = mask[`addr_b`].
  - `busy_d` = `issue_valid` && mask[`issue_addr`].
  - Forwarding is not this block's job: busy stays 1 until the cycle after pop. The register bank's write-through path covers the following read.
- Upstream contract:
  - No issue while `busy_d`; at most one outstanding result per register.
  - No pipeline write to a register whose pending bit is set.
  - Violations are undefined; the assertion fires (see Test Plan).
- Order is preserved between FIFO entries; pipeline writes may overtake queued entries to different registers.

Optional Feature:
- Macro: `WB_MERGE_STATS_EN`.
- Defined:
  - `ml_stall_cnt` increments by 1 on every cycle with `ml_valid`=1 and `ml_ready`=0.
  - Saturates at 32'hFFFFFFFF; cleared by reset.
  - A simulation-only check reports an error on pipeline write to a pending register, or issue to a pending register.
- Not defined: `ml_stall_cnt` is constant 0; no counter or check logic is generated.

Test Plan:
- Reset then idle 5 cycles -> `we`=0, `ml_ready`=1, all busy=0, `addr_d`=0, `data_d`=0.
- Pipe-only path: `pipe_we`=1, `pipe_addr`=3, `pipe_data`=0x1234 for one cycle -> next cycle `we`=1, `addr_d`=3, `data_d`=0x1234; the following cycle `we`=0.
- Issue then drain: `issue_valid` with `issue_addr`=5 -> `busy_a`=1 when `addr_a`=5. Three cycles later `ml_valid`, `ml_addr`=5, `ml_data`=0xDEADBEEF with pipe idle -> `we`=1, `addr_d`=5 next cycle; `busy_a`=0 the cycle after pop.
- Priority and fill:
  - Hold `pipe_we`=1 (`addr`=1) while pushing 4 ml results -> `ml_ready`=0 after the 4th; 5th `ml_valid` is stalled (`ml_stall_cnt`=1 with macro).
  - Drop `pipe_we` -> 4 consecutive ml writes in push order.
- r0 handling: `ml_addr`=0 entry draining -> `we`=0 that cycle. `pipe_we` with `pipe_addr`=0 alongside a non-empty FIFO -> FIFO head is written.
- Reset mid-operation: FIFO holding 3 entries, `reset`=0 for one cycle -> no writes afterwards, `ml_ready`=1, mask 0.
